// File: rtl/gpio_defs.sv
// rtl/gpio_defs.sv - shared constants and helpers for the switch debounce stage
package gpio_defs;

    localparam int GPSW_NUM      = 16;
    localparam int GPSW_TICK_DIV = 50000;
    localparam int GPSW_DB_TICKS = 10;

    // Counter width for a 0..n-1 range; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gpio_db_bit.sv
// rtl/gpio_db_bit.sv - one switch bit: synchroniser, debounce counter, stable level and edge pulses
module gpio_db_bit
    import gpio_defs::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_TICKS    = GPSW_DB_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    input  logic i_tick,
    input  logic i_bypass,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);

    localparam int             CNT_W    = cnt_width(DB_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_TICKS - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_stable;
    logic                   r_rise;
    logic                   r_fall;

    logic w_sync;
    logic w_mismatch;
    logic w_update;

    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign w_mismatch = w_sync ^ r_stable;
    // Accept the new level immediately in bypass, otherwise on the tick that completes the count.
    assign w_update   = w_mismatch & (i_bypass | (i_tick & (r_cnt == CNT_LAST)));

    // Shift the asynchronous pin through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    // Count ticks while the synchronised level disagrees; any agreement or accepted change clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_bypass || !w_mismatch || w_update) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Update the stable level and fire a one-cycle pulse in the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_rise <= w_update & w_sync;
            r_fall <= w_update & ~w_sync;
            if (w_update) begin
                r_stable <= w_sync;
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;

endmodule

// File: rtl/gpio_sw_debounce.sv
// rtl/gpio_sw_debounce.sv - slide-switch conditioning: shared tick prescaler plus per-bit debouncers
module gpio_sw_debounce
    import gpio_defs::*;
#(
    parameter int NUM_SW      = GPSW_NUM,
    parameter int SYNC_STAGES = 2,
    parameter int TICK_DIV    = GPSW_TICK_DIV,
    parameter int DB_TICKS    = GPSW_DB_TICKS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] gp_switch_raw_i,
    input  logic              db_bypass_i,
    output logic [NUM_SW-1:0] sw_stable_o,
    output logic [NUM_SW-1:0] sw_rise_o,
    output logic [NUM_SW-1:0] sw_fall_o
);

    localparam int               DIV_W    = cnt_width(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             w_tick;

    // With TICK_DIV of 1 the counter sits at 0 and the tick is permanently high.
    assign w_tick = (r_div == DIV_LAST);

    // Free-running prescaler shared by all bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_SW; g++) begin : g_bit
        gpio_db_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_TICKS    (DB_TICKS)
        ) u_bit (
            .clk      (clk),
            .rst      (rst),
            .i_raw    (gp_switch_raw_i[g]),
            .i_tick   (w_tick),
            .i_bypass (db_bypass_i),
            .o_stable (sw_stable_o[g]),
            .o_rise   (sw_rise_o[g]),
            .o_fall   (sw_fall_o[g])
        );
    end

endmodule

// File: tb/tb_gpio_sw_debounce.sv
// tb/tb_gpio_sw_debounce.sv - randomized and directed bench for gpio_sw_debounce
module tb_gpio_sw_debounce;

    localparam int N  = 16;
    localparam int S  = 2;
    localparam int TD = 4;
    localparam int DB = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] raw = '0;
    logic         bypass = 1'b0;
    logic [N-1:0] sw_stable_o;
    logic [N-1:0] sw_rise_o;
    logic [N-1:0] sw_fall_o;

    int checks = 0;
    int errors = 0;

    gpio_sw_debounce #(
        .NUM_SW      (N),
        .SYNC_STAGES (S),
        .TICK_DIV    (TD),
        .DB_TICKS    (DB)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .gp_switch_raw_i (raw),
        .db_bypass_i     (bypass),
        .sw_stable_o     (sw_stable_o),
        .sw_rise_o       (sw_rise_o),
        .sw_fall_o       (sw_fall_o)
    );

    always #5 clk = ~clk;

    // Reference model: a bit adopts the synchronised level once the level has
    // disagreed continuously across DB debounce ticks (tick = every TD-th edge
    // after reset), or at once in bypass.
    logic [N-1:0] m_hist [S];
    logic [N-1:0] m_stable = '0;
    logic [N-1:0] m_rise   = '0;
    logic [N-1:0] m_fall   = '0;
    logic [N-1:0] m_sync;
    int           m_ticks [N];
    int           m_k = 0;
    logic         m_tick;
    logic         m_chg;

    always @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < S; j++) m_hist[j] = '0;
            for (int i = 0; i < N; i++) m_ticks[i] = 0;
            m_stable = '0;
            m_rise   = '0;
            m_fall   = '0;
            m_k      = 0;
        end else begin
            m_tick = ((m_k % TD) == TD - 1);
            m_k++;
            m_sync = m_hist[S-1];
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < N; i++) begin
                if (m_sync[i] !== m_stable[i]) begin
                    m_chg = 1'b0;
                    if (bypass) begin
                        m_chg = 1'b1;
                    end else if (m_tick) begin
                        m_ticks[i]++;
                        m_chg = (m_ticks[i] == DB);
                    end
                    if (m_chg) begin
                        m_stable[i] = m_sync[i];
                        m_rise[i]   = m_sync[i];
                        m_fall[i]   = ~m_sync[i];
                        m_ticks[i]  = 0;
                    end
                end else begin
                    m_ticks[i] = 0;
                end
                if (bypass) m_ticks[i] = 0;
            end
            for (int j = S - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = raw;
        end
    end

    task automatic test_reset();
        int lat;
        rst = 1'b1;
        raw = 16'hFFFF;
        bypass = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if ({sw_stable_o, sw_rise_o, sw_fall_o} !== '0) begin
                errors++;
                $display("FAIL reset_outputs got s=%h r=%h f=%h exp 0", sw_stable_o, sw_rise_o, sw_fall_o);
            end
        end
        rst = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(negedge clk);
            checks++;
            if ({sw_stable_o, sw_rise_o, sw_fall_o} !== {m_stable, m_rise, m_fall}) begin
                errors++;
                $display("FAIL reset_model got s=%h r=%h f=%h exp s=%h r=%h f=%h",
                         sw_stable_o, sw_rise_o, sw_fall_o, m_stable, m_rise, m_fall);
            end
            if (sw_stable_o === 16'hFFFF) lat = n;
        end
        checks++;
        if (lat < 11 || lat > 14) begin
            errors++;
            $display("FAIL reset_release_latency got %0d exp 11..14", lat);
        end
        checks++;
        if (sw_rise_o !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_rise_pulse got %h exp ffff", sw_rise_o);
        end
        @(negedge clk);
        checks++;
        if (sw_rise_o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rise_clear got %h exp 0000", sw_rise_o);
        end
    endtask

    task automatic test_bounce();
        int pulses;
        int lat;
        int rises;
        raw = '0;
        repeat (20) @(negedge clk);
        checks++;
        if (sw_stable_o !== 16'h0000) begin
            errors++;
            $display("FAIL bounce_settle got %h exp 0000", sw_stable_o);
        end
        pulses = 0;
        for (int c = 0; c < 36; c++) begin
            if (c < 30 && (c % 3) == 0) raw[3] = ~raw[3];
            if (c == 30) raw[3] = 1'b0;
            @(negedge clk);
            if (sw_stable_o[3] || sw_rise_o[3] || sw_fall_o[3]) pulses++;
            checks++;
            if ({sw_stable_o, sw_rise_o, sw_fall_o} !== {m_stable, m_rise, m_fall}) begin
                errors++;
                $display("FAIL bounce_model got s=%h r=%h f=%h exp s=%h r=%h f=%h",
                         sw_stable_o, sw_rise_o, sw_fall_o, m_stable, m_rise, m_fall);
            end
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL bounce_no_change got %0d active cycles exp 0", pulses);
        end
        raw[3] = 1'b1;
        lat = 0;
        rises = 0;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (sw_rise_o[3]) rises++;
            if (lat == 0 && sw_stable_o[3] === 1'b1) lat = n;
        end
        checks++;
        if (lat < 11 || lat > 14) begin
            errors++;
            $display("FAIL bounce_hold_latency got %0d exp 11..14", lat);
        end
        checks++;
        if (rises != 1) begin
            errors++;
            $display("FAIL bounce_single_rise got %0d exp 1", rises);
        end
    endtask

    task automatic test_simultaneous();
        logic [N-1:0] prev;
        int found;
        raw = 16'h8000;
        repeat (20) @(negedge clk);
        checks++;
        if (sw_stable_o !== 16'h8000) begin
            errors++;
            $display("FAIL simul_settle got %h exp 8000", sw_stable_o);
        end
        raw = 16'h0001;
        found = 0;
        prev = sw_stable_o;
        for (int n = 1; n <= 30 && found == 0; n++) begin
            @(negedge clk);
            if (sw_stable_o !== prev) found = 1;
        end
        checks++;
        if (found == 0 || sw_stable_o !== 16'h0001) begin
            errors++;
            $display("FAIL simul_single_edge got %h exp 0001", sw_stable_o);
        end
        checks++;
        if (sw_rise_o !== 16'h0001 || sw_fall_o !== 16'h8000) begin
            errors++;
            $display("FAIL simul_pulses got r=%h f=%h exp r=0001 f=8000", sw_rise_o, sw_fall_o);
        end
    endtask

    task automatic test_bypass();
        raw = '0;
        repeat (20) @(negedge clk);
        bypass = 1'b1;
        raw = 16'hA5A5;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            checks++;
            if (n < 3 && {sw_stable_o, sw_rise_o, sw_fall_o} !== '0) begin
                errors++;
                $display("FAIL bypass_early n=%0d got s=%h r=%h f=%h exp 0", n, sw_stable_o, sw_rise_o, sw_fall_o);
            end
            if (n == 3 && {sw_stable_o, sw_rise_o, sw_fall_o} !== {16'hA5A5, 16'hA5A5, 16'h0000}) begin
                errors++;
                $display("FAIL bypass_latency got s=%h r=%h f=%h exp s=a5a5 r=a5a5 f=0000", sw_stable_o, sw_rise_o, sw_fall_o);
            end
            if (n == 4 && {sw_stable_o, sw_rise_o, sw_fall_o} !== {16'hA5A5, 16'h0000, 16'h0000}) begin
                errors++;
                $display("FAIL bypass_pulse_end got s=%h r=%h f=%h exp s=a5a5 r=0 f=0", sw_stable_o, sw_rise_o, sw_fall_o);
            end
        end
        raw = '0;
        repeat (5) @(negedge clk);
        bypass = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sw_stable_o, sw_rise_o, sw_fall_o} !== '0) begin
            errors++;
            $display("FAIL bypass_exit got s=%h r=%h f=%h exp 0", sw_stable_o, sw_rise_o, sw_fall_o);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int rises;
        raw = 16'h0001;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({sw_stable_o, sw_rise_o, sw_fall_o} !== '0) begin
                errors++;
                $display("FAIL midrst_outputs got s=%h r=%h f=%h exp 0", sw_stable_o, sw_rise_o, sw_fall_o);
            end
        end
        rst = 1'b0;
        lat = 0;
        rises = 0;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (sw_rise_o[0]) rises++;
            if (lat == 0 && sw_stable_o[0] === 1'b1) lat = n;
        end
        checks++;
        if (lat < 11 || lat > 14) begin
            errors++;
            $display("FAIL midrst_latency got %0d exp 11..14", lat);
        end
        checks++;
        if (rises != 1) begin
            errors++;
            $display("FAIL midrst_single_rise got %0d exp 1", rises);
        end
    endtask

    task automatic test_glitch();
        int act;
        int lat;
        raw = '0;
        repeat (20) @(negedge clk);
        act = 0;
        raw[5] = 1'b1;
        for (int c = 0; c < 28; c++) begin
            if (c == 8) raw[5] = 1'b0;
            @(negedge clk);
            if (sw_stable_o[5] || sw_rise_o[5] || sw_fall_o[5]) act++;
            checks++;
            if ({sw_stable_o, sw_rise_o, sw_fall_o} !== {m_stable, m_rise, m_fall}) begin
                errors++;
                $display("FAIL glitch_model got s=%h r=%h f=%h exp s=%h r=%h f=%h",
                         sw_stable_o, sw_rise_o, sw_fall_o, m_stable, m_rise, m_fall);
            end
        end
        checks++;
        if (act != 0) begin
            errors++;
            $display("FAIL glitch_no_change got %0d active cycles exp 0", act);
        end
        raw[5] = 1'b1;
        lat = 0;
        for (int n = 1; n <= 24 && lat == 0; n++) begin
            @(negedge clk);
            if (sw_stable_o[5] === 1'b1) lat = n;
        end
        checks++;
        if (lat < 11 || lat > 14) begin
            errors++;
            $display("FAIL glitch_count_cleared latency got %0d exp 11..14", lat);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) raw = raw ^ (16'($urandom) & 16'($urandom));
            if ($urandom_range(0, 60) == 0) bypass = ~bypass;
            @(negedge clk);
            checks++;
            if ({sw_stable_o, sw_rise_o, sw_fall_o} !== {m_stable, m_rise, m_fall}) begin
                errors++;
                $display("FAIL random_model cyc=%0d got s=%h r=%h f=%h exp s=%h r=%h f=%h",
                         c, sw_stable_o, sw_rise_o, sw_fall_o, m_stable, m_rise, m_fall);
            end
            checks++;
            if ((sw_rise_o & sw_fall_o) !== 16'h0000) begin
                errors++;
                $display("FAIL random_rise_and_fall cyc=%0d got %h exp 0000", c, sw_rise_o & sw_fall_o);
            end
        end
        bypass = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_simultaneous();
        test_bypass();
        test_reset_mid();
        test_glitch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
